// File: rtl/rx_pkt_packer.sv
// rx_pkt_packer: hard-decision (BPSK/QPSK) bit packer with framed FIFO output.
// Accepted samples are decided on their MSB and packed LSB-first into OW-bit
// words. Completed words are staged for one cycle, written to the FIFO, then
// presented on a registered ready/valid head toward the DMA.
// Optional feature: define RX_PKT_RAW_EN to compile in raw mode (i_mode 2),
// which emits {q, i} per sample and requires OW == 2*DW. Without it, mode 2
// decodes as BPSK.
module rx_pkt_packer #(
  parameter int DW          = 16,
  parameter int OW          = 32,
  parameter int FRAME_WORDS = 64,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic [1:0]    i_mode,
  input  logic [DW-1:0] i_sym_i,
  input  logic [DW-1:0] i_sym_q,
  input  logic          i_sym_vld,
  input  logic          i_sof,
  output logic [OW-1:0] o_dma_data,
  output logic          o_dma_vld,
  output logic          o_dma_last,
  input  logic          i_dma_rdy,
  output logic          o_busy,
  output logic          o_ovf,
  output logic [15:0]   o_ovf_cnt
);

  localparam int SCW = $clog2(OW);
  localparam int WIW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PACK = 1'b1;

  localparam logic [1:0] M_BPSK = 2'd0;
  localparam logic [1:0] M_QPSK = 2'd1;
  localparam logic [1:0] M_RAW  = 2'd2;

  localparam logic [SCW-1:0] BPSK_LAST = SCW'(OW - 1);
  localparam logic [SCW-1:0] QPSK_LAST = SCW'(OW / 2 - 1);
  localparam logic [WIW-1:0] WORD_LAST = WIW'(FRAME_WORDS - 1);

`ifdef RX_PKT_RAW_EN
  if (OW != 2 * DW) begin : g_raw_width_check
    $error("rx_pkt_packer: raw mode requires OW == 2*DW");
  end
`else
  // Only the sign bits matter when the raw path is not built.
  logic w_unused_sym;
  assign w_unused_sym = ^{i_sym_i[DW-2:0], i_sym_q[DW-2:0]};
`endif

  // Packer state
  logic [0:0]     r_state;
  logic [1:0]     r_mode;
  logic [OW-1:0]  r_acc;
  logic [SCW-1:0] r_sym_cnt;
  logic [WIW-1:0] r_word_idx;
  logic           r_push_vld;
  logic [OW-1:0]  r_push_data;
  logic           r_push_last;

  // FIFO state; occupancy counts memory entries plus the output head register
  logic [OW:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_mem_cnt;
  logic           r_head_vld;
  logic [OW-1:0]  r_head_data;
  logic           r_head_last;
  logic           r_ovf;
  logic [15:0]    r_ovf_cnt;

  logic           w_accept;
  logic           w_start;
  logic           w_take;
  logic [1:0]     w_mode_in;
  logic [1:0]     w_mode;
  logic [SCW-1:0] w_qbase;
  logic [OW-1:0]  w_word;
  logic           w_done;
  logic           w_last;
  logic           w_full;
  logic           w_push;
  logic           w_drop;
  logic           w_load;

  assign w_accept = i_en && i_sym_vld;
  assign w_start  = (r_state == ST_IDLE) && w_accept && i_sof;
  assign w_take   = w_start || ((r_state == ST_PACK) && w_accept);
  assign w_mode   = (r_state == ST_IDLE) ? w_mode_in : r_mode;
  assign w_qbase  = r_sym_cnt << 1;
  assign w_last   = (r_word_idx == WORD_LAST);

  // Map the requested mode onto the modes this build supports
  always_comb begin
    w_mode_in = M_BPSK;
    case (i_mode)
      2'd1:    w_mode_in = M_QPSK;
`ifdef RX_PKT_RAW_EN
      2'd2:    w_mode_in = M_RAW;
`endif
      default: w_mode_in = M_BPSK;
    endcase
  end

  // Merge the current sample's decision into the partial word
  always_comb begin
    w_word = r_acc;
    w_done = 1'b0;
    case (w_mode)
      M_QPSK: begin
        w_word[w_qbase +: 2] = {i_sym_q[DW-1], i_sym_i[DW-1]};
        w_done               = (r_sym_cnt == QPSK_LAST);
      end
`ifdef RX_PKT_RAW_EN
      M_RAW: begin
        w_word = {i_sym_q, i_sym_i};
        w_done = 1'b1;
      end
`endif
      default: begin
        w_word[r_sym_cnt] = i_sym_i[DW-1];
        w_done            = (r_sym_cnt == BPSK_LAST);
      end
    endcase
  end

  // Frame state machine and word packer; completed words are staged one cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_mode      <= M_BPSK;
      r_acc       <= '0;
      r_sym_cnt   <= '0;
      r_word_idx  <= '0;
      r_push_vld  <= 1'b0;
      r_push_data <= '0;
      r_push_last <= 1'b0;
    end else begin
      r_push_vld <= 1'b0;
      if ((r_state == ST_PACK) && !i_en) begin
        r_state    <= ST_IDLE;
        r_acc      <= '0;
        r_sym_cnt  <= '0;
        r_word_idx <= '0;
      end else if (w_take) begin
        if (w_start) begin
          r_mode <= w_mode_in;
        end
        if (w_done) begin
          r_push_vld  <= 1'b1;
          r_push_data <= w_word;
          r_push_last <= w_last;
          r_acc       <= '0;
          r_sym_cnt   <= '0;
          if (w_last) begin
            r_word_idx <= '0;
            r_state    <= ST_IDLE;
          end else begin
            r_word_idx <= r_word_idx + WIW'(1);
            r_state    <= ST_PACK;
          end
        end else begin
          r_acc     <= w_word;
          r_sym_cnt <= r_sym_cnt + SCW'(1);
          r_state   <= ST_PACK;
        end
      end
    end
  end

  // Fullness counts the head register and is taken before any same-cycle pop
  assign w_full = (({1'b0, r_mem_cnt} + {{CW{1'b0}}, r_head_vld}) == (CW + 1)'(FIFO_DEPTH));
  assign w_push = r_push_vld && !w_full;
  assign w_drop = r_push_vld && w_full;
  assign w_load = (r_mem_cnt != '0) && (!r_head_vld || i_dma_rdy);

  // FIFO storage write (no reset needed on the data array)
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {r_push_last, r_push_data};
    end
  end

  // FIFO pointers, occupancy and the registered output head
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_mem_cnt   <= '0;
      r_head_vld  <= 1'b0;
      r_head_data <= '0;
      r_head_last <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_load) begin
        {r_head_last, r_head_data} <= r_mem[r_rd_ptr];
        r_rd_ptr                   <= r_rd_ptr + AW'(1);
        r_head_vld                 <= 1'b1;
      end else if (i_dma_rdy) begin
        r_head_vld <= 1'b0;
      end
      r_mem_cnt <= r_mem_cnt + CW'(w_push) - CW'(w_load);
    end
  end

  // Sticky overflow flag and saturating drop counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ovf     <= 1'b0;
      r_ovf_cnt <= '0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (r_ovf_cnt != 16'hFFFF) begin
        r_ovf_cnt <= r_ovf_cnt + 16'd1;
      end
    end
  end

  assign o_dma_data = r_head_data;
  assign o_dma_vld  = r_head_vld;
  assign o_dma_last = r_head_last;
  assign o_busy     = (r_state == ST_PACK);
  assign o_ovf      = r_ovf;
  assign o_ovf_cnt  = r_ovf_cnt;

endmodule

// File: tb/tb_rx_pkt_packer.sv
// tb_rx_pkt_packer: randomized and directed stimulus against a queue-based
// reference model of the packer, FIFO and DMA handshake.
module tb_rx_pkt_packer;

  localparam int DW    = 16;
  localparam int OW    = 32;
  localparam int FW    = 3;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst, en, vld, sof, rdy;
  logic [1:0]    mode;
  logic [DW-1:0] si, sq;
  logic [OW-1:0] dma_data;
  logic          dma_vld, dma_last, busy, ovf;
  logic [15:0]   ovf_cnt;

  always #5 clk = ~clk;

  rx_pkt_packer #(
    .DW          (DW),
    .OW          (OW),
    .FRAME_WORDS (FW),
    .FIFO_DEPTH  (DEPTH)
  ) u_dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_mode     (mode),
    .i_sym_i    (si),
    .i_sym_q    (sq),
    .i_sym_vld  (vld),
    .i_sof      (sof),
    .o_dma_data (dma_data),
    .o_dma_vld  (dma_vld),
    .o_dma_last (dma_last),
    .i_dma_rdy  (rdy),
    .o_busy     (busy),
    .o_ovf      (ovf),
    .o_ovf_cnt  (ovf_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [OW-1:0] data;
    bit            last;
    int            p;     // edge at which the word entered storage
  } ent_t;

  ent_t          fq[$];
  bit            pend_v;
  logic [OW-1:0] pend_d;
  bit            pend_l;
  bit            m_busy;
  int            m_mode;
  logic [63:0]   m_word;
  int            m_nsym;
  int            m_widx;
  bit            m_vld;
  logic [OW-1:0] m_hd;
  bit            m_hl;
  bit            m_ovf;
  int            m_ovf_cnt;
  bit            m_after_rst;
  int            edge_no = 0;

  function automatic int eff_mode(input logic [1:0] m);
    if (m == 2'd1) return 1;
`ifdef RX_PKT_RAW_EN
    if (m == 2'd2) return 2;
`endif
    return 0;
  endfunction

  function automatic int neg(input logic [DW-1:0] v);
    return ($signed(v) < 0) ? 1 : 0;
  endfunction

  task automatic emit(input logic [OW-1:0] w);
    pend_v = 1'b1;
    pend_d = w;
    pend_l = (m_widx == FW - 1);
    m_word = '0;
    m_nsym = 0;
    if (m_widx == FW - 1) begin
      m_widx = 0;
      m_busy = 1'b0;
    end else begin
      m_widx++;
    end
  endtask

  task automatic model_edge();
    bit full;
    edge_no++;
    if (rst) begin
      fq.delete();
      pend_v = 0; m_busy = 0; m_mode = 0; m_word = '0; m_nsym = 0; m_widx = 0;
      m_vld = 0; m_ovf = 0; m_ovf_cnt = 0; m_after_rst = 1;
      return;
    end
    m_after_rst = 0;
    full = (fq.size() == DEPTH);
    if (m_vld && rdy) void'(fq.pop_front());
    if (pend_v) begin
      if (full) begin
        m_ovf = 1;
        if (m_ovf_cnt < 65535) m_ovf_cnt++;
      end else begin
        fq.push_back('{data: pend_d, last: pend_l, p: edge_no});
      end
    end
    pend_v = 0;
    if (m_busy && !en) begin
      m_busy = 0; m_word = '0; m_nsym = 0; m_widx = 0;
    end else if (en && vld && (m_busy || sof)) begin
      if (!m_busy) begin
        m_mode = eff_mode(mode);
        m_busy = 1;
      end
      if (m_mode == 2) begin
        emit({sq, si});
      end else if (m_mode == 1) begin
        m_word = m_word | (64'(neg(si) + 2 * neg(sq)) << (2 * m_nsym));
        m_nsym++;
        if (m_nsym == OW / 2) emit(m_word[OW-1:0]);
      end else begin
        m_word = m_word | (64'(neg(si)) << m_nsym);
        m_nsym++;
        if (m_nsym == OW) emit(m_word[OW-1:0]);
      end
    end
    m_vld = (fq.size() > 0) && (fq[0].p < edge_no);
    if (m_vld) begin
      m_hd = fq[0].data;
      m_hl = fq[0].last;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic compare_outputs();
    chk("vld", 64'(dma_vld), 64'(m_vld));
    if (m_vld) begin
      chk("data", 64'(dma_data), 64'(m_hd));
      chk("last", 64'(dma_last), 64'(m_hl));
    end
    if (m_after_rst) begin
      chk("rst_data", 64'(dma_data), 64'd0);
      chk("rst_last", 64'(dma_last), 64'd0);
    end
    chk("busy", 64'(busy), 64'(m_busy));
    chk("ovf", 64'(ovf), 64'(m_ovf));
    chk("ovf_cnt", 64'(ovf_cnt), 64'(m_ovf_cnt));
  endtask

  task automatic drive(input bit r, input bit e, input logic [1:0] md,
                       input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input bit v, input bit s, input bit rd);
    rst = r; en = e; mode = md; si = a; sq = b; vld = v; sof = s; rdy = rd;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    compare_outputs();
  endtask

  function automatic bit rdy_for(input int kind);
    case (kind)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return ((cyc / 3) % 2) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  function automatic logic [DW-1:0] rnd_sample();
    case ($urandom_range(0, 5))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'h0000;
      3:       return 16'hFFFF;
      default: return DW'($urandom);
    endcase
  endfunction

  task automatic idle(input int n, input int rk);
    for (int unsigned k = 0; k < n; k++)
      drive(0, 1, 2'd0, '0, '0, 0, 0, rdy_for(rk));
  endtask

  // kind: 0 random data, 1 I alternating +100/-100, 2 (I,Q) = (-1,+1)
  task automatic send_frame(input logic [1:0] md, input int kind, input int rk);
    int n = 0;
    logic [DW-1:0] a, b;
    while ((n == 0 || m_busy) && n < 2000) begin
      case (kind)
        1:       begin a = (n % 2 == 0) ? 16'd100 : 16'hFF9C; b = 16'd5; end
        2:       begin a = 16'hFFFF; b = 16'h0001; end
        default: begin a = rnd_sample(); b = rnd_sample(); end
      endcase
      // mode and SOF after the first sample must be ignored
      drive(0, 1, (n == 0) ? md : 2'($urandom), a, b, 1,
            (n == 0) ? 1'b1 : 1'($urandom_range(0, 1)), rdy_for(rk));
      n++;
    end
    if (n >= 2000) chk("frame_bound", 64'(n), 64'd0);
  endtask

  initial begin
    rst = 1; en = 0; mode = 0; si = '0; sq = '0; vld = 0; sof = 0; rdy = 0;
    @(negedge clk);

    drive(1, 0, 2'd0, '0, '0, 0, 0, 0);
    drive(1, 0, 2'd0, '0, '0, 0, 0, 0);
    idle(3, 1);

    // BPSK alternating pattern, then QPSK (-1,+1) pattern
    send_frame(2'd0, 1, 1);
    idle(6, 1);
    send_frame(2'd1, 2, 1);
    idle(6, 1);

    // Mode 2 with DMA stalled: two frames overflow the storage, then drain
    send_frame(2'd2, 0, 0);
    send_frame(2'd2, 0, 0);
    idle(4, 0);
    idle(12, 1);

    // Toggling backpressure across several frames
    for (int unsigned f = 0; f < 4; f++) send_frame(2'($urandom), 0, 2);
    idle(12, 2);

    // Enable dropped mid-frame after 10 BPSK samples, then a fresh frame
    drive(0, 1, 2'd0, 16'hFFFF, '0, 1, 1, 1);
    for (int unsigned k = 0; k < 9; k++) drive(0, 1, 2'd0, rnd_sample(), '0, 1, 0, 1);
    drive(0, 0, 2'd0, '0, '0, 1, 1, 1);
    send_frame(2'd0, 1, 1);
    idle(6, 1);

    // Reset with a full frame buffered and the DMA stalled
    send_frame(2'd0, 0, 0);
    idle(3, 0);
    drive(1, 0, 2'd0, '0, '0, 0, 0, 0);
    idle(10, 1);

    // Randomized traffic
    for (int unsigned k = 0; k < 4000; k++) begin
      drive(($urandom_range(0, 799) == 0),
            ($urandom_range(0, 39) != 0),
            2'($urandom),
            rnd_sample(), rnd_sample(),
            ($urandom_range(0, 9) < 8),
            ($urandom_range(0, 19) == 0),
            rdy_for((k / 500) % 4));
    end
    idle(20, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
